// File: rtl/led_pattern_sequencer_if.sv
// rtl/led_pattern_sequencer_if.sv - pattern table write port (valid/ready)
interface led_pattern_sequencer_if #(
  parameter int NUM_LEDS  = 4,
  parameter int NUM_STEPS = 8,
  parameter int DUR_W     = 16
);
  localparam int SW = (NUM_STEPS > 1) ? $clog2(NUM_STEPS) : 1;

  logic                i_cfg_valid;
  logic                o_cfg_ready;
  logic [SW-1:0]       i_cfg_addr;
  logic [NUM_LEDS-1:0] i_cfg_mask;
  logic [3:0]          i_cfg_rate;
  logic [DUR_W-1:0]    i_cfg_dur;

  modport master (
    output i_cfg_valid, i_cfg_addr, i_cfg_mask, i_cfg_rate, i_cfg_dur,
    input  o_cfg_ready
  );

  modport slave (
    input  i_cfg_valid, i_cfg_addr, i_cfg_mask, i_cfg_rate, i_cfg_dur,
    output o_cfg_ready
  );
endinterface

// File: rtl/led_pattern_sequencer.sv
// rtl/led_pattern_sequencer.sv - programmable step table driving a led_controller bank
module led_pattern_sequencer #(
  parameter int  NUM_LEDS  = 4,
  parameter int  NUM_STEPS = 8,
  parameter int  DUR_W     = 16,
  localparam int SW        = (NUM_STEPS > 1) ? $clog2(NUM_STEPS) : 1
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  led_pattern_sequencer_if.slave   cfg,
  input  logic                     i_start,
  input  logic                     i_stop,
  input  logic                     i_loop,
  input  logic [SW-1:0]            i_last_step,
  output logic [NUM_LEDS-1:0]      o_led_enable,
  output logic [3:0]               o_blink_rate,
  output logic [SW-1:0]            o_step,
  output logic                     o_busy,
  output logic                     o_done
);
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t              state_q, state_d;
  logic [SW-1:0]       step_q, step_d;
  logic [SW-1:0]       last_q, last_d;
  logic                loop_q, loop_d;
  logic [DUR_W-1:0]    cnt_q, cnt_d;
  logic [NUM_LEDS-1:0] enable_q, enable_d;
  logic [3:0]          rate_q, rate_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  logic [NUM_LEDS-1:0] tbl_mask_q [NUM_STEPS];
  logic [NUM_LEDS-1:0] tbl_mask_d [NUM_STEPS];
  logic [3:0]          tbl_rate_q [NUM_STEPS];
  logic [3:0]          tbl_rate_d [NUM_STEPS];
  logic [DUR_W-1:0]    tbl_dur_q  [NUM_STEPS];
  logic [DUR_W-1:0]    tbl_dur_d  [NUM_STEPS];

  logic [SW-1:0]       last_clamped;
  logic                addr_ok;
  logic                load;
  logic [SW-1:0]       load_idx;

  // Clamping only matters when the index width can name entries past the table.
  if ((1 << SW) > NUM_STEPS) begin : g_clamp
    assign last_clamped = (i_last_step > SW'(NUM_STEPS - 1)) ? SW'(NUM_STEPS - 1) : i_last_step;
    assign addr_ok      = (cfg.i_cfg_addr <= SW'(NUM_STEPS - 1));
  end else begin : g_noclamp
    assign last_clamped = i_last_step;
    assign addr_ok      = 1'b1;
  end

  assign cfg.o_cfg_ready = (state_q == S_IDLE);

  always_comb begin
    state_d    = state_q;
    step_d     = step_q;
    last_d     = last_q;
    loop_d     = loop_q;
    cnt_d      = cnt_q;
    enable_d   = enable_q;
    rate_d     = rate_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    tbl_mask_d = tbl_mask_q;
    tbl_rate_d = tbl_rate_q;
    tbl_dur_d  = tbl_dur_q;
    load       = 1'b0;
    load_idx   = '0;

    case (state_q)
      S_IDLE: begin
        enable_d = '0;
        rate_d   = '0;
        step_d   = '0;
        busy_d   = 1'b0;
        if (cfg.i_cfg_valid && addr_ok) begin
          tbl_mask_d[cfg.i_cfg_addr] = cfg.i_cfg_mask;
          tbl_rate_d[cfg.i_cfg_addr] = cfg.i_cfg_rate;
          tbl_dur_d[cfg.i_cfg_addr]  = cfg.i_cfg_dur;
        end
        // Step 0 is loaded from the pre-write table contents.
        if (i_start && !i_stop) begin
          state_d  = S_RUN;
          loop_d   = i_loop;
          last_d   = last_clamped;
          busy_d   = 1'b1;
          load     = 1'b1;
          load_idx = '0;
        end
      end
      S_RUN: begin
        if (i_stop) begin
          state_d  = S_IDLE;
          enable_d = '0;
          rate_d   = '0;
          step_d   = '0;
          busy_d   = 1'b0;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else if (step_q < last_q) begin
          load     = 1'b1;
          load_idx = step_q + 1'b1;
        end else if (loop_q) begin
          load     = 1'b1;
          load_idx = '0;
        end else begin
          state_d  = S_DONE;
          enable_d = '0;
          rate_d   = '0;
          step_d   = '0;
          busy_d   = 1'b0;
          done_d   = 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (load) begin
      step_d   = load_idx;
      enable_d = tbl_mask_q[load_idx];
      rate_d   = tbl_rate_q[load_idx];
      cnt_d    = (tbl_dur_q[load_idx] == '0) ? '0 : tbl_dur_q[load_idx] - 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q  <= S_IDLE;
      step_q   <= '0;
      last_q   <= '0;
      loop_q   <= 1'b0;
      cnt_q    <= '0;
      enable_q <= '0;
      rate_q   <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      for (int i = 0; i < NUM_STEPS; i++) begin
        tbl_mask_q[i] <= '0;
        tbl_rate_q[i] <= '0;
        tbl_dur_q[i]  <= '0;
      end
    end else begin
      state_q    <= state_d;
      step_q     <= step_d;
      last_q     <= last_d;
      loop_q     <= loop_d;
      cnt_q      <= cnt_d;
      enable_q   <= enable_d;
      rate_q     <= rate_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      tbl_mask_q <= tbl_mask_d;
      tbl_rate_q <= tbl_rate_d;
      tbl_dur_q  <= tbl_dur_d;
    end
  end

  assign o_led_enable = enable_q;
  assign o_blink_rate = rate_q;
  assign o_step       = step_q;
  assign o_busy       = busy_q;
  assign o_done       = done_q;
endmodule

// File: tb/tb_led_pattern_sequencer.sv
// tb/tb_led_pattern_sequencer.sv - scoreboard bench for led_pattern_sequencer
module tb_led_pattern_sequencer;
  localparam int NL = 4;
  localparam int NS = 8;
  localparam int DW = 16;
  localparam int SW = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          i_start = 1'b0;
  logic          i_stop = 1'b0;
  logic          i_loop = 1'b0;
  logic [SW-1:0] i_last_step = '0;
  logic [NL-1:0] o_led_enable;
  logic [3:0]    o_blink_rate;
  logic [SW-1:0] o_step;
  logic          o_busy;
  logic          o_done;

  always #5 clk = ~clk;

  led_pattern_sequencer_if #(.NUM_LEDS(NL), .NUM_STEPS(NS), .DUR_W(DW)) cfg_if ();

  led_pattern_sequencer #(.NUM_LEDS(NL), .NUM_STEPS(NS), .DUR_W(DW)) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .cfg          (cfg_if),
    .i_start      (i_start),
    .i_stop       (i_stop),
    .i_loop       (i_loop),
    .i_last_step  (i_last_step),
    .o_led_enable (o_led_enable),
    .o_blink_rate (o_blink_rate),
    .o_step       (o_step),
    .o_busy       (o_busy),
    .o_done       (o_done)
  );

  typedef struct packed {
    logic [NL-1:0] en;
    logic [3:0]    rate;
    logic [SW-1:0] step;
    logic          busy;
    logic          done;
    logic          ready;
  } exp_t;

  exp_t          sb[$];
  int            checks = 0;
  int            errors = 0;
  logic [NL-1:0] m_mask [NS];
  logic [3:0]    m_rate [NS];
  logic [DW-1:0] m_dur  [NS];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic void push_exp(logic [NL-1:0] en, logic [3:0] rate, logic [SW-1:0] step,
                                   logic busy, logic done);
    exp_t e;
    e.en    = en;
    e.rate  = rate;
    e.step  = step;
    e.busy  = busy;
    e.done  = done;
    e.ready = !busy && !done;
    sb.push_back(e);
  endfunction

  function automatic void push_idle();
    push_exp('0, '0, '0, 1'b0, 1'b0);
  endfunction

  function automatic void push_run(int last, int reps, bit loop);
    for (int r = 0; r < reps; r++)
      for (int s = 0; s <= last; s++)
        for (int d = 0; d < ((m_dur[s] == '0) ? 1 : int'(m_dur[s])); d++)
          push_exp(m_mask[s], m_rate[s], SW'(s), 1'b1, 1'b0);
    if (!loop) begin
      push_exp('0, '0, '0, 1'b0, 1'b1);
      push_idle();
    end
  endfunction

  task automatic check_pop(string tag);
    exp_t e;
    exp_t o;
    o = {o_led_enable, o_blink_rate, o_step, o_busy, o_done, cfg_if.o_cfg_ready};
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $error("FAIL %s: scoreboard empty, observed %h", tag, o);
    end else begin
      e = sb.pop_front();
      assert (o === e) else begin
        errors++;
        $error("FAIL %s: observed %h expected %h", tag, o, e);
      end
    end
  endtask

  task automatic drain(string tag);
    while (sb.size() > 0) begin
      tick();
      check_pop(tag);
    end
  endtask

  task automatic cfg_write(int addr, logic [NL-1:0] mask, logic [3:0] rate, logic [DW-1:0] dur);
    cfg_if.i_cfg_valid = 1'b1;
    cfg_if.i_cfg_addr  = SW'(addr);
    cfg_if.i_cfg_mask  = mask;
    cfg_if.i_cfg_rate  = rate;
    cfg_if.i_cfg_dur   = dur;
    checks++;
    assert (cfg_if.o_cfg_ready === 1'b1) else begin
      errors++;
      $error("FAIL cfg_ready_idle: observed %b expected 1", cfg_if.o_cfg_ready);
    end
    tick();
    cfg_if.i_cfg_valid = 1'b0;
    m_mask[addr] = mask;
    m_rate[addr] = rate;
    m_dur[addr]  = dur;
  endtask

  task automatic start_run(int last, bit loop);
    i_last_step = SW'(last);
    i_loop      = loop;
    i_start     = 1'b1;
    tick();
    i_start     = 1'b0;
  endtask

  initial begin
    int n1;
    cfg_if.i_cfg_valid = 1'b0;
    cfg_if.i_cfg_addr  = '0;
    cfg_if.i_cfg_mask  = '0;
    cfg_if.i_cfg_rate  = '0;
    cfg_if.i_cfg_dur   = '0;
    for (int i = 0; i < NS; i++) begin
      m_mask[i] = '0;
      m_rate[i] = '0;
      m_dur[i]  = '0;
    end

    tick();
    tick();
    push_idle();
    check_pop("reset");
    rst_n = 1'b1;

    // 1: two-step one-shot
    cfg_write(0, 4'b0001, 4'd2, 16'd3);
    cfg_write(1, 4'b1010, 4'd5, 16'd1);
    push_run(1, 1, 1'b0);
    start_run(1, 1'b0);
    check_pop("t1_run");
    drain("t1_run");

    // 2: looping, then abort
    push_run(1, 2, 1'b1);
    start_run(1, 1'b1);
    check_pop("t2_loop");
    drain("t2_loop");
    i_stop = 1'b1;
    push_idle();
    tick();
    i_stop = 1'b0;
    check_pop("t2_stop");

    // 3: full table, zero durations held one cycle
    for (int s = 0; s < NS; s++)
      cfg_write(s, NL'(s + 1), 4'(15 - s), DW'(s % 3));
    push_run(7, 1, 1'b0);
    start_run(7, 1'b0);
    check_pop("t3_full");
    drain("t3_full");

    // 4: writes during RUN are refused
    push_run(7, 1, 1'b0);
    start_run(7, 1'b0);
    check_pop("t4_run_cfg");
    cfg_if.i_cfg_valid = 1'b1;
    cfg_if.i_cfg_addr  = 3'd2;
    cfg_if.i_cfg_mask  = 4'hf;
    cfg_if.i_cfg_rate  = 4'h0;
    cfg_if.i_cfg_dur   = 16'd9;
    repeat (3) begin
      tick();
      check_pop("t4_run_cfg");
    end
    cfg_if.i_cfg_valid = 1'b0;
    drain("t4_run_cfg");
    push_run(7, 1, 1'b0);
    start_run(7, 1'b0);
    check_pop("t4_replay");
    drain("t4_replay");

    // 4b: write and start in the same cycle plays the old entry 0
    push_run(0, 1, 1'b0);
    cfg_if.i_cfg_valid = 1'b1;
    cfg_if.i_cfg_addr  = 3'd0;
    cfg_if.i_cfg_mask  = 4'hf;
    cfg_if.i_cfg_rate  = 4'd9;
    cfg_if.i_cfg_dur   = 16'd2;
    i_last_step = 3'd0;
    i_loop      = 1'b0;
    i_start     = 1'b1;
    tick();
    i_start            = 1'b0;
    cfg_if.i_cfg_valid = 1'b0;
    m_mask[0] = 4'hf;
    m_rate[0] = 4'd9;
    m_dur[0]  = 16'd2;
    check_pop("t4_wr_start");
    drain("t4_wr_start");
    push_run(0, 1, 1'b0);
    start_run(0, 1'b0);
    check_pop("t4_new_e0");
    drain("t4_new_e0");

    // 5: reset mid-RUN at step 1 clears the table
    push_exp(m_mask[0], m_rate[0], 3'd0, 1'b1, 1'b0);
    push_exp(m_mask[0], m_rate[0], 3'd0, 1'b1, 1'b0);
    push_exp(m_mask[1], m_rate[1], 3'd1, 1'b1, 1'b0);
    start_run(7, 1'b0);
    check_pop("t5_pre");
    tick();
    check_pop("t5_pre");
    tick();
    check_pop("t5_pre");
    rst_n = 1'b0;
    push_idle();
    tick();
    rst_n = 1'b1;
    check_pop("t5_rst");
    for (int i = 0; i < NS; i++) begin
      m_mask[i] = '0;
      m_rate[i] = '0;
      m_dur[i]  = '0;
    end
    push_run(1, 1, 1'b0);
    start_run(1, 1'b0);
    check_pop("t5_zero");
    drain("t5_zero");

    // 6: stop beats start in IDLE; held start gives back-to-back runs
    i_start = 1'b1;
    i_stop  = 1'b1;
    repeat (2) begin
      push_idle();
      tick();
      check_pop("t6_start_stop");
    end
    i_start = 1'b0;
    i_stop  = 1'b0;
    cfg_write(0, 4'b0110, 4'd3, 16'd2);
    cfg_write(1, 4'b1001, 4'd7, 16'd0);
    push_run(1, 1, 1'b0);
    n1 = sb.size();
    push_run(1, 1, 1'b0);
    i_last_step = 3'd1;
    i_loop      = 1'b0;
    i_start     = 1'b1;
    for (int i = 0; i < n1 + 1; i++) begin
      tick();
      check_pop("t6_held");
    end
    i_start = 1'b0;
    drain("t6_held");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
